usb_status_tx: RTL and testbench

Transmit side of the FT245-style USB FIFO link: frames a 5-byte status packet (header, sequence number, panel switch state, checksum) and writes it byte-by-byte to the USB FIFO through the shared 8-bit bus. Sits beside `usb_controller` (the receive path) at the top level. It drives `wr_n` and the bus-out enable, and yields to the receiver while a receive transfer is in progress.

---
 rtl/usb_status_tx.sv | 157 +++++++++++++++
 tb/tb_usb_status_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_status_tx.sv
// FT245-style USB FIFO transmit framer: sends a 5-byte status packet (header, seq, switches, xor).
// Optional USB_STATUS_TX_CHANGE_DETECT_EN: a switch change while idle queues a packet like send_request.
module usb_status_tx #(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned WR_PULSE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter logic [7:0]  HEADER          = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] panel_switches,
  input  logic        send_request,
  input  logic        rx_active,
  input  logic        txe_n_raw,
  output logic [7:0]  data_bus_out,
  output logic        data_out_enable,
  output logic        wr_n,
  output logic        tx_busy,
  output logic        packet_done,
  output logic [7:0]  seq_num
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_TXE, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_DONE
  } state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(WR_PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [7:0]  seq_q, seq_d;
  logic        pend_q, pend_d;
  logic        txe_meta_q, txe_meta_d;
  logic        txe_sync_n_q, txe_sync_n_d;
  logic        change;
  logic [7:0]  cur_byte;

`ifdef USB_STATUS_TX_CHANGE_DETECT_EN
  logic [15:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == S_LOAD) last_d = panel_switches;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 16'h0000;
    else       last_q <= last_d;
  end

  assign change = (state_q == S_IDLE) && (panel_switches != last_q);
`else
  assign change = 1'b0;
`endif

  // A request seen during LOAD survives the clear so it becomes the follow-on packet.
  always_comb begin
    txe_meta_d   = txe_n_raw;
    txe_sync_n_d = txe_meta_q;
    pend_d       = send_request | change | (pend_q & (state_q != S_LOAD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'h00;
      idx_q        <= 3'd0;
      snap_q       <= 16'h0000;
      seq_q        <= 8'h00;
      pend_q       <= 1'b0;
      txe_meta_q   <= 1'b1;
      txe_sync_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      seq_q        <= seq_d;
      pend_q       <= pend_d;
      txe_meta_q   <= txe_meta_d;
      txe_sync_n_q <= txe_sync_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    seq_d   = seq_q;
    case (state_q)
      S_IDLE: if (pend_q) state_d = S_LOAD;
      S_LOAD: begin
        snap_d  = panel_switches;
        idx_d   = 3'd0;
        state_d = S_WAIT_TXE;
      end
      S_WAIT_TXE: if (!txe_sync_n_q && !rx_active) begin
        state_d = S_SETUP;
        cnt_d   = 8'h00;
      end
      S_SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = S_STROBE;
        cnt_d   = 8'h00;
      end else cnt_d = cnt_q + 8'h01;
      S_STROBE: if (cnt_q == STROBE_LAST) begin
        state_d = S_HOLD;
        cnt_d   = 8'h00;
      end else cnt_d = cnt_q + 8'h01;
      S_HOLD: if (cnt_q == HOLD_LAST) begin
        state_d = S_NEXT;
        cnt_d   = 8'h00;
      end else cnt_d = cnt_q + 8'h01;
      S_NEXT: if (idx_q == 3'd4) begin
        state_d = S_DONE;
        seq_d   = seq_q + 8'h01;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = S_WAIT_TXE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = seq_q;
      3'd2:    cur_byte = snap_q[15:8];
      3'd3:    cur_byte = snap_q[7:0];
      default: cur_byte = HEADER ^ seq_q ^ snap_q[15:8] ^ snap_q[7:0];
    endcase
  end

  always_comb begin
    data_out_enable = 1'b0;
    wr_n            = 1'b1;
    packet_done     = 1'b0;
    tx_busy         = (state_q != S_IDLE);
    case (state_q)
      S_SETUP, S_HOLD: data_out_enable = 1'b1;
      S_STROBE: begin
        data_out_enable = 1'b1;
        wr_n            = 1'b0;
      end
      S_DONE:  packet_done = 1'b1;
      default: ;
    endcase
    data_bus_out = data_out_enable ? cur_byte : 8'h00;
  end

  assign seq_num = seq_q;
endmodule

// File: tb/tb_usb_status_tx.sv
// Scoreboard bench for usb_status_tx: stimulus queues expected packets, a monitor decodes the bus.
module tb_usb_status_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] panel_switches = 16'h0000;
  logic        send_request = 1'b0;
  logic        rx_active = 1'b0;
  logic        txe_n_raw = 1'b0;
  logic [7:0]  data_bus_out;
  logic        data_out_enable, wr_n, tx_busy, packet_done;
  logic [7:0]  seq_num;

  usb_status_tx dut (
    .clk(clk), .reset(reset), .panel_switches(panel_switches),
    .send_request(send_request), .rx_active(rx_active), .txe_n_raw(txe_n_raw),
    .data_bus_out(data_bus_out), .data_out_enable(data_out_enable), .wr_n(wr_n),
    .tx_busy(tx_busy), .packet_done(packet_done), .seq_num(seq_num)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] sw;
    logic [7:0]  seq;
    bit          ideal;
  } pkt_t;

  pkt_t       exp_q[$];
  int         checks = 0, passed = 0;
  int         fall_cnt = 0;
  bit         rnd_bg = 1'b0;
  logic [7:0] model_seq = 8'h00;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [7:0] pkt_byte(input pkt_t p, input int i);
    logic [7:0] b[5];
    b[0] = 8'hA5;
    b[1] = p.seq;
    b[2] = p.sw[15:8];
    b[3] = p.sw[7:0];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    return b[i];
  endfunction

  // Monitor: decodes wr_n strobes into bytes, scores packets on packet_done.
  initial begin
    logic [7:0] got[5];
    logic [7:0] cur_b;
    int nbytes, low_cnt, cyc, t_load;
    bit prev_wr, prev_oe, prev_rx, prev_busy;
    pkt_t p;
    nbytes = 0; low_cnt = 0; cyc = 0; t_load = 0; cur_b = 8'h00;
    prev_wr = 1'b1; prev_oe = 1'b0; prev_rx = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        nbytes = 0; low_cnt = 0;
        prev_wr = 1'b1; prev_oe = 1'b0; prev_rx = rx_active; prev_busy = 1'b0;
      end else begin
        if (!data_out_enable) chk(data_bus_out == 8'h00, "bus idle value", data_bus_out, 0);
        if (!wr_n) begin
          if (prev_wr) begin
            chk(data_out_enable, "oe during strobe", data_out_enable, 1);
            cur_b = data_bus_out;
            if (nbytes < 5) got[nbytes] = data_bus_out;
            nbytes++;
            fall_cnt++;
          end else chk(data_bus_out == cur_b, "byte stable in strobe", data_bus_out, cur_b);
          low_cnt++;
        end else if (!prev_wr) begin
          chk(low_cnt == 3, "wr_n low width", low_cnt, 3);
          low_cnt = 0;
        end
        if (data_out_enable && !prev_oe) chk(!prev_rx, "setup while rx_active", prev_rx, 0);
        if (tx_busy && !prev_busy) t_load = cyc;
        if (packet_done) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected packet", seq_num, 0);
          else begin
            p = exp_q.pop_front();
            chk(nbytes == 5, "byte count", nbytes, 5);
            for (int i = 0; i < 5; i++)
              if (i < nbytes) chk(got[i] == pkt_byte(p, i), $sformatf("byte %0d", i), got[i], pkt_byte(p, i));
            chk(seq_num == p.seq + 8'h01, "seq_num after done", seq_num, p.seq + 8'h01);
            if (p.ideal) chk(cyc - t_load == 41, "LOAD to packet_done", cyc - t_load, 41);
          end
          nbytes = 0;
        end
        prev_wr = wr_n; prev_oe = data_out_enable; prev_rx = rx_active; prev_busy = tx_busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bg) begin
      rx_active = ($urandom % 4) == 0;
      txe_n_raw = ($urandom % 5) == 0;
    end
  endtask

  task automatic push(input logic [15:0] sw, input bit ideal);
    pkt_t p;
    p.sw = sw; p.seq = model_seq; p.ideal = ideal;
    exp_q.push_back(p);
    model_seq = model_seq + 8'h01;
  endtask

  task automatic send(input logic [15:0] sw, input bit ideal);
    tick();
    panel_switches = sw;
    send_request = 1'b1;
    push(sw, ideal);
    tick();
    send_request = 1'b0;
  endtask

  task automatic req_only();
    tick();
    send_request = 1'b1;
    tick();
    send_request = 1'b0;
  endtask

  task automatic wait_fall(input int target);
    int n = 0;
    while (fall_cnt < target && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk(1'b0, "wait for strobe timeout", fall_cnt, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 6000) begin tick(); n++; end
    if (n >= 6000) chk(1'b0, "wait for idle timeout", exp_q.size(), 0);
  endtask

  initial begin
    int base, n, bad;
    logic [15:0] sw;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(data_bus_out == 8'h00, "reset data_bus_out", data_bus_out, 0);
    chk(!data_out_enable, "reset oe", data_out_enable, 0);
    chk(wr_n, "reset wr_n", wr_n, 1);
    chk(!tx_busy, "reset tx_busy", tx_busy, 0);
    chk(!packet_done, "reset packet_done", packet_done, 0);
    chk(seq_num == 8'h00, "reset seq_num", seq_num, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) tick();

    // Single ideal packet: A5 00 12 C3 74
    send(16'h12C3, 1'b1);
    wait_idle();
    chk(seq_num == 8'h01, "seq after first packet", seq_num, 1);

    // FIFO back-pressure after byte 1
    base = fall_cnt;
    send(16'hBEEF, 1'b0);
    wait_fall(base + 2);
    txe_n_raw = 1'b1;
    repeat (6) tick();
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (data_out_enable || !wr_n) bad++;
    end
    chk(bad == 0, "bus quiet while txe_n high", bad, 0);
    tick();
    txe_n_raw = 1'b0;
    n = 0;
    while (!data_out_enable && n < 10) begin tick(); n++; end
    chk(n >= 2 && n <= 3, "resume latency", n, 3);
    wait_idle();

    // rx_active rises mid-strobe of byte 2, then blocks byte 3
    base = fall_cnt;
    send(16'h3C96, 1'b0);
    wait_fall(base + 3);
    rx_active = 1'b1;
    repeat (10) tick();
    chk(!data_out_enable, "held off by rx_active", data_out_enable, 0);
    repeat (5) tick();
    rx_active = 1'b0;
    wait_idle();

    // Three requests mid-packet collapse into one follow-on
    base = fall_cnt;
    send(16'h7E01, 1'b0);
    wait_fall(base + 1);
    push(16'h7E01, 1'b0);
    repeat (3) begin req_only(); repeat (4) tick(); end
    wait_idle();
    repeat (5) tick();
    chk(!tx_busy, "no extra packet after collapse", tx_busy, 0);

    // Random traffic with random rx_active / txe_n
    rnd_bg = 1'b1;
    for (int it = 0; it < 20; it++) begin
      sw = 16'($urandom);
      base = fall_cnt;
      send(sw, 1'b0);
      if ($urandom % 2 == 1) begin
        wait_fall(base + 1 + int'($urandom % 4));
        push(sw, 1'b0);
        req_only();
      end
      wait_idle();
    end
    rnd_bg = 1'b0;
    rx_active = 1'b0;
    txe_n_raw = 1'b0;
    repeat (4) tick();

    // Reset during STROBE of byte 2
    base = fall_cnt;
    send(16'h5A5A, 1'b0);
    wait_fall(base + 3);
    reset = 1'b1;
    panel_switches = 16'h0000;
    tick();
    chk(wr_n, "abort wr_n", wr_n, 1);
    chk(!data_out_enable, "abort oe", data_out_enable, 0);
    chk(seq_num == 8'h00, "abort seq_num", seq_num, 0);
    chk(!tx_busy, "abort tx_busy", tx_busy, 0);
    exp_q.delete();
    model_seq = 8'h00;
    reset = 1'b0;
    bad = 0;
    repeat (20) begin tick(); if (tx_busy) bad++; end
    chk(bad == 0, "no packet after reset", bad, 0);

    // 256 packets wrap seq_num
    for (int it = 0; it < 256; it++) begin
      send(16'($urandom), 1'b1);
      wait_idle();
    end
    chk(seq_num == 8'h00, "seq_num wrap", seq_num, 0);

`ifdef USB_STATUS_TX_CHANGE_DETECT_EN
    tick();
    panel_switches = 16'h0000;
    push(16'h0000, 1'b0);
    wait_idle();
    tick();
    panel_switches = 16'h0001;
    push(16'h0001, 1'b0);
    wait_idle();
    bad = 0;
    repeat (100) begin tick(); if (tx_busy) bad++; end
    chk(bad == 0, "steady switches send nothing", bad, 0);
`endif

    repeat (5) tick();
    chk(exp_q.size() == 0, "scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
